// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one single-port memory bus between the
// instruction-fetch port and the data port, with flush draining and bus timeout.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic [DW-1:0]   if_rdata_o,
    output logic            if_ack_o,

    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [DW/8-1:0] dm_sel_i,
    input  logic [AW-1:0]   dm_addr_i,
    input  logic [DW-1:0]   dm_wdata_i,
    output logic [DW-1:0]   dm_rdata_o,
    output logic            dm_ack_o,

    input  logic            flush_i,

    output logic            bus_cyc_o,
    output logic            bus_we_o,
    output logic [DW/8-1:0] bus_sel_o,
    output logic [AW-1:0]   bus_addr_o,
    output logic [DW-1:0]   bus_wdata_o,
    input  logic [DW-1:0]   bus_rdata_i,
    input  logic            bus_ack_i,

    output logic            stall_req_o,
    output logic            err_o
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_dm_q, last_dm_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            if_ack_q, if_ack_d;
    logic            dm_ack_q, dm_ack_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            err_q, err_d;

    logic            if_vld, dm_vld;
    logic            grant_dm, grant_if;
    logic [8:0]      tmo_inc;
    logic            tmo_hit;

    // A port acked this cycle is masked so a held request is not served twice;
    // a flush also hides the fetch request for the cycle it is asserted.
    assign if_vld   = if_req_i & ~if_ack_q & ~flush_i;
    assign dm_vld   = dm_req_i & ~dm_ack_q;
    assign grant_dm = dm_vld & (~if_vld | ~last_dm_q);
    assign grant_if = if_vld & ~grant_dm;

    assign tmo_inc  = {1'b0, tmo_q} + 9'd1;
    assign tmo_hit  = ~bus_ack_i & (tmo_inc >= 9'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dm_q  <= 1'b0;
            tmo_q      <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            last_dm_q  <= last_dm_d;
            tmo_q      <= tmo_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_dm_d  = last_dm_q;
        tmo_d      = tmo_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;

        if (state_q != IDLE && !bus_ack_i) begin
            tmo_d = tmo_inc[7:0];
        end

        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_d   = GNT_DM;
                    last_dm_d = 1'b1;
                    tmo_d     = '0;
                    cyc_d     = 1'b1;
                    we_d      = dm_we_i;
                    sel_d     = dm_sel_i;
                    addr_d    = dm_addr_i;
                    wdata_d   = dm_wdata_i;
                end else if (grant_if) begin
                    state_d   = GNT_IF;
                    last_dm_d = 1'b0;
                    tmo_d     = '0;
                    cyc_d     = 1'b1;
                    we_d      = 1'b0;
                    sel_d     = '1;
                    addr_d    = if_addr_i;
                    wdata_d   = '0;
                end
            end

            GNT_IF: begin
                // A flush arriving with the completion simply drops the data.
                if (bus_ack_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    if (!flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_rdata_i;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!flush_i) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end

            GNT_DM: begin
                if (bus_ack_i) begin
                    state_d  = IDLE;
                    cyc_d    = 1'b0;
                    dm_ack_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = bus_rdata_i;
                    end
                end else if (tmo_hit) begin
                    state_d  = IDLE;
                    cyc_d    = 1'b0;
                    err_d    = 1'b1;
                    dm_ack_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = '0;
                    end
                end
            end

            DRAIN: begin
                // The abandoned fetch still owns the bus until the slave completes.
                if (bus_ack_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign bus_cyc_o   = cyc_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign err_o       = err_q;
    assign stall_req_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
